// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel rise/fall/both edge pulses with saturating event counts.
// Define MULTI_EDGE_SYNC_EN to add a two-flop synchronizer on signal_in (adds 2 cycles latency and priming).
module multi_edge_detector #(
    parameter int WIDTH        = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             signal_in,
    input  logic [2*WIDTH-1:0]           mode,
    input  logic [WIDTH-1:0]             count_clear,
    output logic [WIDTH-1:0]             edge_detect_pulse,
    output logic [WIDTH*COUNT_WIDTH-1:0] edge_count
);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PLOAD = PW'(PULSE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] det;
    logic             primed;
    logic [1:0]       pc;
`ifdef MULTI_EDGE_SYNC_EN
    localparam logic [1:0] PRIME_LAST = 2'd2;
    logic [WIDTH-1:0] sync1, sync2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
        end
    end
    assign s = sync2;
`else
    localparam logic [1:0] PRIME_LAST = 2'd0;
    assign s = signal_in;
`endif
    // prev tracks the input even while priming, so a level held through reset is never an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= '0;
            primed <= 1'b0;
            pc     <= '0;
        end else begin
            prev <= s;
            if (!primed) begin
                pc     <= pc + 2'd1;
                primed <= (pc == PRIME_LAST);
            end
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [1:0]             m;
        logic [PW-1:0]          pcnt;
        logic [COUNT_WIDTH-1:0] cnt;
        assign m      = mode[2*i +: 2];
        assign det[i] = primed & ((m[0] & s[i] & ~prev[i]) | (m[1] & ~s[i] & prev[i]));
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pcnt <= '0;
                cnt  <= '0;
            end else begin
                pcnt <= det[i] ? PLOAD : (pcnt != '0) ? pcnt - PW'(1) : pcnt;
                cnt  <= count_clear[i] ? COUNT_WIDTH'(det[i]) :
                        (det[i] && cnt != CMAX) ? cnt + COUNT_WIDTH'(1) : cnt;
            end
        end
        assign edge_detect_pulse[i]                      = (pcnt != '0);
        assign edge_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
    end
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed and random stimulus against a history-based reference model.
module tb_multi_edge_detector;
    localparam int W  = 4;
    localparam int P  = 3;
    localparam int CW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0]    signal_in   = '0;
    logic [W-1:0]    count_clear = '0;
    logic [2*W-1:0]  mode        = '0;
    logic [W-1:0]    edge_detect_pulse;
    logic [W*CW-1:0] edge_count;
    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] samples[$];
    int last_det[W];
    int cnt_m[W];

    always #5 clk = ~clk;

    multi_edge_detector #(.WIDTH(W), .PULSE_CYCLES(P), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode),
        .count_clear(count_clear), .edge_detect_pulse(edge_detect_pulse), .edge_count(edge_count)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        samples.delete();
        for (int c = 0; c < W; c++) begin
            last_det[c] = -100;
            cnt_m[c] = 0;
        end
    endtask

    // every sample after the first in a reset epoch is compared with its predecessor
    task automatic step(input logic [W-1:0] s, input logic [2*W-1:0] md, input logic [W-1:0] clr);
        signal_in = s;
        mode = md;
        count_clear = clr;
        @(posedge clk);
        samples.push_back(s);
        for (int c = 0; c < W; c++) begin
            bit d;
            d = 1'b0;
            if (samples.size() > 1) begin
                bit a, b;
                a = samples[samples.size()-2][c];
                b = samples[samples.size()-1][c];
                d = (md[2*c] && b && !a) || (md[2*c+1] && a && !b);
            end
            if (d) last_det[c] = samples.size();
            if (clr[c]) cnt_m[c] = int'(d);
            else if (d && cnt_m[c] < (1 << CW) - 1) cnt_m[c]++;
        end
        #1;
        for (int c = 0; c < W; c++) begin
            check($sformatf("pulse%0d", c), 8'(edge_detect_pulse[c]), 8'((samples.size() - last_det[c]) < P));
            check($sformatf("count%0d", c), 8'(edge_count[c*CW +: CW]), 8'(cnt_m[c]));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse", 8'(edge_detect_pulse), 8'd0);
        check("rst_count", 8'(edge_count), 8'd0);
        // high levels held through reset release must not be reported
        signal_in = '1;
        mode = '1;
        rst = 1'b0;
        model_reset();
        repeat (4) step(4'b1111, 8'hFF, 4'b0000);
        check("held_high_count", 8'(edge_count), 8'd0);
        repeat (3) step(4'b0000, 8'h00, 4'b1111);
        // rising on ch0/ch1
        repeat (5) step(4'b0001, 8'b00_00_01_01, 4'b0000);
        repeat (5) step(4'b0000, 8'b00_00_01_01, 4'b0000);
        repeat (3) step(4'b0010, 8'b00_00_01_01, 4'b0000);
        repeat (3) step(4'b0000, 8'b00_00_01_01, 4'b0000);
        check("rise_cnt0", 8'(edge_count[0 +: CW]), 8'd1);
        check("rise_cnt1", 8'(edge_count[CW +: CW]), 8'd1);
        step(4'b0000, 8'b00_00_01_01, 4'b0011);
        // falling ch0, both ch1
        repeat (4) step(4'b0011, 8'b00_00_11_10, 4'b0000);
        repeat (4) step(4'b0000, 8'b00_00_11_10, 4'b0000);
        check("fall_cnt0", 8'(edge_count[0 +: CW]), 8'd1);
        check("both_cnt1", 8'(edge_count[CW +: CW]), 8'd2);
        // one-cycle toggle in both mode, then retrigger in rising mode
        step(4'b0001, 8'b00_00_00_11, 4'b0001);
        repeat (4) step(4'b0000, 8'b00_00_00_11, 4'b0000);
        step(4'b0001, 8'b00_00_00_01, 4'b0001);
        step(4'b0000, 8'b00_00_00_01, 4'b0000);
        step(4'b0001, 8'b00_00_00_01, 4'b0000);
        repeat (5) step(4'b0001, 8'b00_00_00_01, 4'b0000);
        check("retrig_cnt", 8'(edge_count[0 +: CW]), 8'd2);
        // saturation on ch2
        for (int k = 0; k < 9; k++) begin
            step(4'b0100, 8'b00_01_00_00, 4'b0000);
            step(4'b0000, 8'b00_01_00_00, 4'b0000);
        end
        check("sat_cnt", 8'(edge_count[2*CW +: CW]), 8'd7);
        step(4'b0100, 8'b00_01_00_00, 4'b0100);
        check("clr_edge", 8'(edge_count[2*CW +: CW]), 8'd1);
        step(4'b0100, 8'b00_01_00_00, 4'b0100);
        check("clr_alone", 8'(edge_count[2*CW +: CW]), 8'd0);
        // mode 00 on ch3; ch0 pulse survives its mode being switched off
        for (int k = 0; k < 10; k++) step(4'(k[0] ? 4'b1000 : 4'b0000), 8'b00_00_00_00, 4'b0000);
        step(4'b0000, 8'b00_00_00_00, 4'b0000);
        step(4'b0001, 8'b00_00_00_01, 4'b0000);
        repeat (3) step(4'b0001, 8'b01_00_00_00, 4'b0000);
        check("mode00_cnt3", 8'(edge_count[3*CW +: CW]), 8'd0);
        // random traffic
        for (int k = 0; k < 400; k++)
            step(W'($urandom), (2*W)'($urandom), ($urandom_range(0, 7) == 0) ? W'($urandom) : '0);
        // reset mid-pulse clears outputs without a clock edge
        step(4'b0000, 8'hFF, 4'b0000);
        step(4'b1111, 8'hFF, 4'b0000);
        #2 rst = 1'b1;
        #1;
        check("midrst_pulse", 8'(edge_detect_pulse), 8'd0);
        check("midrst_count", 8'(edge_count), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (3) step(4'b1111, 8'hFF, 4'b0000);
        repeat (4) step(4'b0101, 8'hFF, 4'b0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel edge detector, successor to the single-mode rising-edge detector used on debounced button inputs. Each channel independently detects rising, falling or both edges. Each channel produces an output pulse of configurable width and keeps a saturating per-channel event count. It sits between the button/switch conditioning chain and the control FSMs that consume one-shot events.

## Interface
- `WIDTH`, default 2: number of independent channels; must be ≥1.
- `PULSE_CYCLES`, default 1: width of each output pulse in `clk` cycles; must be ≥1.
- `COUNT_WIDTH`, default 8: width of each per-channel event counter.

- `clk`, input, 1: the only clock; all state is updated on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `signal_in`, input, `WIDTH`: level inputs, one bit per channel. They must be synchronous to `clk` unless `MULTI_EDGE_SYNC_EN` is defined.
- `mode`, input, `2*WIDTH`: per-channel mode; channel i uses `mode[2i+1:2i]`. Encoding: 00 = off, 01 = rising, 10 = falling, 11 = both.
- `count_clear`, input, `WIDTH`: per-channel synchronous clear for the event counter.
- `edge_detect_pulse`, output, `WIDTH`: per-channel registered pulse output.
- `edge_count`, output, `WIDTH*COUNT_WIDTH`: per-channel event counts; channel i uses bits `[(i+1)*COUNT_WIDTH-1 : i*COUNT_WIDTH]`.

## Operation
- Per-channel state:
  - `prev`, the last sampled input.
  - Pulse down-counter `pcnt`, width `$clog2(PULSE_CYCLES+1)`.
  - Event counter `cnt`.
- Global `primed` flag.
- Reset values (asynchronous): `prev`=0, `pcnt`=0, `cnt`=0, `primed`=0. Therefore `edge_detect_pulse`=0 and `edge_count`=0.
- Priming: in the first clock cycle after `rst` deasserts, `prev` loads `signal_in` and `primed` is set. No detection occurs in that cycle. A level that is already high when reset releases is therefore never reported as an edge.
- Every later cycle, each channel computes:
  - `rise = s & ~prev` and `fall = ~s & prev`, where `s` is the sampled input.
  - `det = (mode[0] & rise) | (mode[1] & fall)`.
  - `prev` is updated to `s`.
- Per-channel pulse logic:
  - `det` loads `pcnt` with `PULSE_CYCLES`. A retrigger while a pulse is active restarts the full width.
  - Otherwise, if `pcnt` ≠ 0, it decrements.
  - `edge_detect_pulse[i] = (pcnt ≠ 0)`.
- Event counter update, per channel:
  - `count_clear` with `det` in the same cycle: `cnt` ← 1.
  - `count_clear` alone: `cnt` ← 0.
  - `det` alone: `cnt` ← `cnt`+1, saturating at 2^`COUNT_WIDTH`−1 with no wrap.
- Mode rules:
  - Mode 00 suppresses detection and counting, but `prev` still tracks the input.
  - Changing `mode` never truncates a pulse already in flight.
- Channels are fully independent; simultaneous edges on several channels are all reported in the same cycle.

## Timing
- Latency: suppose `signal_in` changes to a value that is stable before posedge k. Then `edge_detect_pulse` rises just after posedge k and stays high for exactly `PULSE_CYCLES` cycles.
- `edge_count` increments at the same posedge k.
- An input toggle lasting a single cycle in mode 11 produces two detections in consecutive cycles. With `PULSE_CYCLES`=1 the pulse is high for 2 cycles and the count rises by 2.
- `rst` asserted mid-pulse clears the outputs immediately, without waiting for a clock edge. Priming repeats after release.
- Outputs are register-driven only; there is no combinational path from any input to any output.

## Configuration
- `MULTI_EDGE_SYNC_EN` defined:
  - A two-flop synchronizer (reset to 0) is inserted on each `signal_in` bit before `prev`.
  - Detection latency grows by 2 cycles.
  - The priming window becomes 3 cycles after reset release, so the synchronizer fills before `prev` loads.
- `MULTI_EDGE_SYNC_EN` undefined: `signal_in` is sampled directly, with the latency and priming given above.

## Test plan
- WIDTH=2, PULSE_CYCLES=1, mode=0b0101:
  - Stimulus: `signal_in` 00→01 held 5 cycles, →00 for 5, →10 for 3, →00.
  - Response: exactly one 1-cycle pulse on bit 0, then one on bit 1; `edge_count` = {1,1}.
- Falling and both modes: mode ch0=10, ch1=11; toggle both channels high then low.
  - Response: ch0 pulses only on the fall; ch1 pulses on both edges.
  - Counts {1,2}.
- Stretch and retrigger: PULSE_CYCLES=4, rising mode; edges at cycles 0 and 2.
  - Response: the pulse stays high for 6 contiguous cycles.
  - Count = 2.
- Saturation and clear:
  - COUNT_WIDTH=3 with 9 rising edges: count holds at 7.
  - `count_clear` coincident with an edge: count becomes 1.
  - `count_clear` alone: count becomes 0.
- Reset boundaries:
  - Hold `signal_in`=11 through reset release: no pulse, count 0.
  - Assert `rst` mid-pulse: pulse drops within the same cycle.
- Mode 00: 10 toggles on a channel give no pulse and count 0. Switching to 01 mid-pulse on another channel leaves that pulse at full width.
